store_buffer: RTL and testbench

- Store staging queue in the memory stage; sits directly upstream of the data memory and feeds its write port.
- Accepts store requests (sw/sh/sb) from the pipeline and generates the byte-enable mask and lane-replicated write data.
- Rejects misaligned or out-of-range stores with an exception flag.
- Buffers up to DEPTH stores, drains them in order when the memory signals ready, and flags loads that hit a pending store word.

---
 rtl/store_buffer.sv | 150 +++++++++++++++
 tb/tb_store_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store staging queue: byte-enable/lane encoding, in-order drain to data memory, load hazard detection
module store_buffer #(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] ADDR_LIMIT = 32'h00003000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        st_valid,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    output logic        st_exc,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    output logic        ld_hazard,
    input  logic        dm_ready,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memData,
    output logic [3:0]  BE,
    output logic [31:0] pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] TYPE_SW = 2'b00;
    localparam logic [1:0] TYPE_SH = 2'b01;
    localparam logic [1:0] TYPE_SB = 2'b10;
    localparam logic [1:0] TYPE_NONE = 2'b11;

    logic [29:0] q_addr [DEPTH];
    logic [31:0] q_data [DEPTH];
    logic [3:0]  q_be   [DEPTH];
    logic [31:0] q_pc   [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             empty;
    logic             full;
    logic             is_req;
    logic             misalign;
    logic             out_of_range;
    logic             push;
    logic             pop;
    logic [3:0]       be_enc;
    logic [31:0]      data_enc;
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_hit;
    logic [PTR_W-1:0] rel;
    logic             unused_ld_bits;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    assign st_ready = ~full;

    // Reserved type is treated as no request at all, so it can never raise an exception.
    assign is_req = st_valid & (st_type != TYPE_NONE);

    always_comb begin
        misalign = 1'b0;
        case (st_type)
            TYPE_SW: misalign = (st_addr[1:0] != 2'b00);
            TYPE_SH: misalign = st_addr[0];
            default: misalign = 1'b0;
        endcase
    end

    assign out_of_range = (st_addr >= ADDR_LIMIT);
    assign st_exc       = is_req & (misalign | out_of_range);

    assign push = is_req & ~st_exc & st_ready;
    assign pop  = ~empty & dm_ready;

    always_comb begin
        be_enc   = 4'b1111;
        data_enc = st_data;
        case (st_type)
            TYPE_SH: begin
                be_enc   = st_addr[1] ? 4'b1100 : 4'b0011;
                data_enc = {2{st_data[15:0]}};
            end
            TYPE_SB: begin
                be_enc   = 4'b0001 << st_addr[1:0];
                data_enc = {4{st_data[7:0]}};
            end
            default: begin
                be_enc   = 4'b1111;
                data_enc = st_data;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: entries are only observed while counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= st_addr[31:2];
            q_data[tail] <= data_enc;
            q_be[tail]   <= be_enc;
            q_pc[tail]   <= st_pc;
        end
    end

    assign memWrite = ~empty;
    assign memAddr  = empty ? 32'h0 : {q_addr[head], 2'b00};
    assign memData  = empty ? 32'h0 : q_data[head];
    assign BE       = empty ? 4'h0  : q_be[head];
    assign pc       = empty ? 32'h0 : q_pc[head];

    // An entry is live when its distance from head is below count; the popping head still counts.
    always_comb begin
        rel       = '0;
        ent_valid = '0;
        ent_hit   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel          = PTR_W'(i) - head;
            ent_valid[i] = ({1'b0, rel} < count);
            ent_hit[i]   = ent_valid[i] & (q_addr[i] == ld_addr[31:2]);
        end
    end

    assign ld_hazard      = ld_valid & (|ent_hit);
    assign unused_ld_bits = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer: vector table, corner sequences, randomized model comparison
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        st_valid;
    logic [1:0]  st_type;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [31:0] st_pc;
    logic        st_ready;
    logic        st_exc;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        dm_ready;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic [3:0]  BE;
    logic [31:0] pc;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .ADDR_LIMIT(32'h00003000)) dut (
        .clk(clk), .reset_n(reset_n),
        .st_valid(st_valid), .st_type(st_type), .st_addr(st_addr),
        .st_data(st_data), .st_pc(st_pc), .st_ready(st_ready), .st_exc(st_exc),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
        .dm_ready(dm_ready), .memWrite(memWrite), .memAddr(memAddr),
        .memData(memData), .BE(BE), .pc(pc)
    );

    typedef struct {
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] spc;
        logic        exc;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] mdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] spc;
    } ent_t;

    vec_t vecs[10];
    ent_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        st_valid = 1'b0; st_type = 2'b00; st_addr = '0; st_data = '0; st_pc = '0;
        ld_valid = 1'b0; ld_addr = '0;
    endtask

    task automatic drive_sw(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        st_valid = 1'b1; st_type = 2'b00; st_addr = a; st_data = d; st_pc = 32'h1000 + a;
        @(posedge clk);
        #1 st_valid = 1'b0;
    endtask

    function automatic ent_t model_enc(input logic [1:0] t, input logic [31:0] a,
                                       input logic [31:0] d, input logic [31:0] p);
        ent_t e;
        e.addr = a - (a % 4);
        e.spc  = p;
        if (t == 2'd0) begin
            e.be = 4'hF; e.data = d;
        end else if (t == 2'd1) begin
            e.be   = (a % 4 >= 2) ? 4'hC : 4'h3;
            e.data = (d % 65536) * 32'h00010001;
        end else begin
            e.be   = 4'(1 << (a % 4));
            e.data = (d % 256) * 32'h01010101;
        end
        return e;
    endfunction

    function automatic logic model_exc(input logic v, input logic [1:0] t, input logic [31:0] a);
        if (!v || t == 2'd3) return 1'b0;
        if (a >= 32'h3000) return 1'b1;
        if (t == 2'd0 && a % 4 != 0) return 1'b1;
        if (t == 2'd1 && a % 2 != 0) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        idle_inputs();
        dm_ready = 1'b1;
        reset_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_memWrite", 32'(memWrite), 0);
        chk("rst_BE", 32'(BE), 0);
        chk("rst_memAddr", memAddr, 0);
        chk("rst_st_ready", 32'(st_ready), 1);
        chk("rst_st_exc", 32'(st_exc), 0);
        chk("rst_ld_hazard", 32'(ld_hazard), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // typ, addr, data, pc, exc, written, BE, memData
        vecs[0] = '{2'd2, 32'h00000005, 32'h000000AB, 32'h00003010, 1'b0, 1'b1, 4'b0010, 32'hABABABAB};
        vecs[1] = '{2'd1, 32'h00000102, 32'h00005A5A, 32'h00000020, 1'b0, 1'b1, 4'b1100, 32'h5A5A5A5A};
        vecs[2] = '{2'd1, 32'h00000101, 32'h00001234, 32'h00000024, 1'b1, 1'b0, 4'b0000, 32'h0};
        vecs[3] = '{2'd0, 32'h00003000, 32'hDEADBEEF, 32'h00000028, 1'b1, 1'b0, 4'b0000, 32'h0};
        vecs[4] = '{2'd3, 32'h00000040, 32'h11111111, 32'h0000002C, 1'b0, 1'b0, 4'b0000, 32'h0};
        vecs[5] = '{2'd2, 32'h00002FFF, 32'hFFFFFF7E, 32'h00000030, 1'b0, 1'b1, 4'b1000, 32'h7E7E7E7E};
        vecs[6] = '{2'd1, 32'h00002FFC, 32'hABCD9876, 32'h00000034, 1'b0, 1'b1, 4'b0011, 32'h98769876};
        vecs[7] = '{2'd0, 32'h00002FFC, 32'hCAFEF00D, 32'h00000038, 1'b0, 1'b1, 4'b1111, 32'hCAFEF00D};
        vecs[8] = '{2'd0, 32'h00000002, 32'h01234567, 32'h0000003C, 1'b1, 1'b0, 4'b0000, 32'h0};
        vecs[9] = '{2'd2, 32'h00000000, 32'h00000011, 32'h00000040, 1'b0, 1'b1, 4'b0001, 32'h11111111};

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dm_ready = 1'b1;
            st_valid = 1'b1; st_type = vecs[i].typ; st_addr = vecs[i].addr;
            st_data = vecs[i].data; st_pc = vecs[i].spc;
            #1 chk($sformatf("v%0d_exc", i), 32'(st_exc), 32'(vecs[i].exc));
            @(negedge clk);
            st_valid = 1'b0;
            #1;
            chk($sformatf("v%0d_wr", i), 32'(memWrite), 32'(vecs[i].wr));
            chk($sformatf("v%0d_be", i), 32'(BE), 32'(vecs[i].be));
            chk($sformatf("v%0d_data", i), memData, vecs[i].mdata);
            chk($sformatf("v%0d_addr", i), memAddr, vecs[i].wr ? {vecs[i].addr[31:2], 2'b00} : 32'h0);
            chk($sformatf("v%0d_pc", i), pc, vecs[i].wr ? vecs[i].spc : 32'h0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_drained", i), 32'({memWrite, BE}), 0);
        end

        // Fill the queue with memory stalled, then drain in order.
        @(negedge clk);
        dm_ready = 1'b0;
        for (int k = 0; k < 4; k++) drive_sw(32'(4 * k), 32'hA0 + 32'(k));
        @(negedge clk);
        chk("full_st_ready", 32'(st_ready), 0);
        st_valid = 1'b1; st_type = 2'b00; st_addr = 32'h10; st_data = 32'hBAD;
        @(posedge clk);
        #1 st_valid = 1'b0;
        dm_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_addr", k), memAddr, 32'(4 * k));
            chk($sformatf("drain%0d_data", k), memData, 32'hA0 + 32'(k));
            if (k == 1) chk("drain_ready_after_pop", 32'(st_ready), 1);
        end
        @(negedge clk);
        chk("fifth_not_accepted", 32'(memWrite), 0);

        // Load hazard against a pending store word.
        dm_ready = 1'b0;
        drive_sw(32'h10, 32'h55);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'h12;
        #1 chk("haz_0x12", 32'(ld_hazard), 1);
        ld_addr = 32'h14;
        #1 chk("haz_0x14", 32'(ld_hazard), 0);
        ld_valid = 1'b0; ld_addr = 32'h12;
        #1 chk("haz_ld_invalid", 32'(ld_hazard), 0);
        ld_valid = 1'b1; dm_ready = 1'b1;
        #1 chk("haz_while_popping", 32'(ld_hazard), 1);
        @(negedge clk);
        #1 chk("haz_after_drain", 32'(ld_hazard), 0);
        ld_valid = 1'b0;

        // Asynchronous reset with three entries queued.
        dm_ready = 1'b0;
        for (int k = 0; k < 3; k++) drive_sw(32'h100 + 32'(4 * k), 32'(k));
        @(negedge clk);
        chk("pre_rst_memWrite", 32'(memWrite), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_memWrite", 32'(memWrite), 0);
        chk("async_rst_st_ready", 32'(st_ready), 1);
        @(negedge clk);
        reset_n = 1'b1;
        dm_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_no_stale", 32'(memWrite), 0);

        // Randomized traffic against a queue model.
        mq.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            ent_t e;
            logic exp_exc, exp_haz, accept;
            @(negedge clk);
            st_valid = ($urandom_range(0, 3) != 0);
            st_type  = 2'($urandom_range(0, 3));
            st_addr  = ($urandom_range(0, 9) == 0) ? 32'h3000 + $urandom_range(0, 255)
                                                   : $urandom_range(0, 32'h2FFF);
            st_data  = $urandom;
            st_pc    = $urandom;
            dm_ready = ($urandom_range(0, 2) == 0);
            ld_valid = $urandom_range(0, 1);
            if (mq.size() > 0 && $urandom_range(0, 1) == 1)
                ld_addr = mq[$urandom_range(0, mq.size() - 1)].addr + $urandom_range(0, 3);
            else
                ld_addr = $urandom_range(0, 32'h2FFF);
            #1;
            exp_exc = model_exc(st_valid, st_type, st_addr);
            exp_haz = 1'b0;
            foreach (mq[j]) if (mq[j].addr / 4 == ld_addr / 4) exp_haz = ld_valid;
            chk("rnd_st_exc", 32'(st_exc), 32'(exp_exc));
            chk("rnd_st_ready", 32'(st_ready), 32'(mq.size() < 4));
            chk("rnd_ld_hazard", 32'(ld_hazard), 32'(exp_haz));
            chk("rnd_memWrite", 32'(memWrite), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("rnd_memAddr", memAddr, mq[0].addr);
                chk("rnd_memData", memData, mq[0].data);
                chk("rnd_BE", 32'(BE), 32'(mq[0].be));
                chk("rnd_pc", pc, mq[0].spc);
            end
            accept = st_valid && st_type != 2'd3 && !exp_exc && mq.size() < 4;
            if (mq.size() != 0 && dm_ready) void'(mq.pop_front());
            if (accept) begin
                e = model_enc(st_type, st_addr, st_data, st_pc);
                mq.push_back(e);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
